time_set_counter: RTL and testbench
===================================

Name: time_set_counter

Overview:
- Downstream consumer of the slide-switch pulse generator.
- Holds the running clock time (hours, minutes, seconds) as packed two-digit BCD and advances seconds on a 1 Hz strobe.
- In set mode, each rising edge of the pulse-generator output adds one to the selected field (minutes or hours).
- Outputs drive the seven-segment display decoder.

Parameters:
- HOUR_MAX, 23: last hour value before hours wrap to 00; must be 1..99.
- REPEAT_CYCLES, 25000000: clock cycles per auto-repeat step. Used only when AUTO_REPEAT_EN is defined.

Ports:
- i_clk  in  1  system clock, 50 MHz
- i_rst  in  1  synchronous reset, active-high
- i_tick  in  1  one-cycle 1 Hz strobe
- i_set_en  in  1  set mode: 1 = setting, 0 = running
- i_sel  in  1  field select in set mode: 0 = minutes, 1 = hours
- i_pulse  in  1  pulse-generator output, level; a rising edge requests one increment
- o_sec_bcd  out  8  seconds, {tens, ones} BCD, 00..59
- o_min_bcd  out  8  minutes, {tens, ones} BCD, 00..59
- o_hour_bcd  out  8  hours, {tens, ones} BCD, 00..HOUR_MAX
- o_carry_day  out  1  one-cycle strobe on rollover from HOUR_MAX:59:59 to 00:00:00

Behaviour:
- Clocking: one clock, i_clk. Reset is synchronous and active-high on i_rst; no asynchronous paths.
- Reset values: all time outputs 00, o_carry_day 0, edge-detect register pulse_q = 1, repeat counter 0.
  - pulse_q resets to 1 so that i_pulse held high through reset release causes no increment.
- Edge detect:
  - inc_req = i_pulse & ~pulse_q.
  - pulse_q <= i_pulse every cycle, in both modes.
- Running mode (i_set_en = 0):
  - i_pulse edges are ignored.
  - On i_tick: seconds +1.
  - Seconds 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours; hours HOUR_MAX -> 00.
  - Full rollover HOUR_MAX:59:59 -> 00:00:00 asserts o_carry_day for exactly the next cycle. It is registered alongside the time values.
- Set mode (i_set_en = 1):
  - i_tick is ignored.
  - Seconds are forced to 00 every cycle.
  - On inc_req:
    - If i_sel = 0: minutes +1, wrapping 59 -> 00 with no carry into hours.
    - If i_sel = 1: hours +1, wrapping HOUR_MAX -> 00.
  - o_carry_day is never asserted in set mode.
- Latency: one cycle from the clock edge that samples the rising i_pulse, or i_tick, to the updated output value.
- BCD arithmetic:
  - Ones digit 9 -> 0 with tens +1.
  - Wrap compare is on the full packed byte against the BCD form of 59 or HOUR_MAX.
  - Illegal BCD codes are never produced.
- Simultaneous events:
  - i_set_en is sampled in the same cycle as i_tick or inc_req; the mode in that cycle decides which event is acted on.
  - A rising edge of i_set_en and an i_pulse edge in the same cycle: the increment is applied and seconds clear.
  - i_sel changing in the same cycle as inc_req: the new i_sel value selects the field.
- Reset mid-operation: all state returns to reset values at the next clock edge. Any in-progress repeat count is discarded.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined:
  - In set mode, while i_pulse stays high after an accepted edge, a counter runs.
  - Every REPEAT_CYCLES cycles it issues one further increment on the selected field.
  - The counter clears on i_pulse = 0, on i_set_en = 0, on i_rst, and on any change of i_sel.
- When undefined:
  - Only rising edges of i_pulse increment.
  - The repeat counter logic is absent.

Test Plan:
- Reset with i_pulse held 1, release reset -> outputs 00:00:00; no increment until i_pulse goes 0 then 1.
- Running mode, preset 23:59:58, two i_tick strobes -> 23:59:59, then 00:00:00 with o_carry_day high for exactly one cycle.
- Set mode, i_sel = 0, minutes = 58, three i_pulse rising edges -> 59, 00, 01; hours unchanged; seconds 00 throughout; i_tick strobes ignored.
- Set mode, i_sel = 1, HOUR_MAX = 23, hours = 22, two edges -> 23, 00. Repeat with HOUR_MAX = 11, hours = 11, one edge -> 00.
- Same cycle i_tick = 1 and a rising i_pulse with i_set_en = 0 at 10:20:30 -> 10:20:31, minutes unchanged. Same stimulus with i_set_en = 1 and i_sel = 0 -> 10:21:00.
- AUTO_REPEAT_EN defined, REPEAT_CYCLES = 4, i_pulse held high 13 cycles in set mode, i_sel = 0, minutes = 05 -> minutes reach 08 (one edge increment plus three repeats); i_pulse = 0 stops further increments.

Source files
------------

// File: rtl/time_set_counter.sv
// time_set_counter
// Running clock time (hh:mm:ss, packed two-digit BCD) advanced by a 1 Hz
// strobe, with a set mode that bumps minutes or hours on each rising edge
// of the slide-switch pulse-generator output.
//
// Optional feature macro: AUTO_REPEAT_EN
//   Defined   : holding i_pulse high in set mode issues one extra increment
//               every REPEAT_CYCLES cycles after the accepted edge.
//   Undefined : only rising edges of i_pulse increment.
//
// Parameters:
//   HOUR_MAX      last hour value before hours wrap to 00 (1..99)
//   REPEAT_CYCLES cycles per auto-repeat step (AUTO_REPEAT_EN only)
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_tick       one-cycle 1 Hz strobe
//   i_set_en     1 = set mode, 0 = running
//   i_sel        set-mode field select: 0 = minutes, 1 = hours
//   i_pulse      pulse-generator level; rising edge requests one increment
//   o_sec_bcd    seconds {tens, ones}
//   o_min_bcd    minutes {tens, ones}
//   o_hour_bcd   hours {tens, ones}
//   o_carry_day  one-cycle strobe on HOUR_MAX:59:59 -> 00:00:00
module time_set_counter #(
  parameter int HOUR_MAX      = 23,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_set_en,
  input  logic       i_sel,
  input  logic       i_pulse,
  output logic [7:0] o_sec_bcd,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_hour_bcd,
  output logic       o_carry_day
);

  localparam logic [7:0] C_MAX59 = 8'h59;
  localparam logic [3:0] C_HOUR_TENS = 4'(HOUR_MAX / 10);
  localparam logic [3:0] C_HOUR_ONES = 4'(HOUR_MAX % 10);
  localparam logic [7:0] C_HOUR_MAX_BCD = {C_HOUR_TENS, C_HOUR_ONES};

  if (HOUR_MAX < 1 || HOUR_MAX > 99 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("time_set_counter: HOUR_MAX must be 1..99 and REPEAT_CYCLES >= 1");
  end

  // Wrap is decided on the whole packed byte, so only legal codes appear.
  function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [7:0] r_sec, r_min, r_hour;
  logic       r_carry_day;
  logic       r_pulse_q;

  logic [7:0] w_sec_nxt, w_min_nxt, w_hour_nxt;
  logic       w_carry_nxt;
  logic       w_inc_req;
  logic       w_rep_inc;
  logic       w_set_inc;

  // r_pulse_q resets to 1 so a pulse held high across reset release is not
  // mistaken for a rising edge.
  assign w_inc_req = i_pulse & ~r_pulse_q;

`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [CW-1:0] C_REP_LAST = CW'(REPEAT_CYCLES - 1);

  logic          r_rep_active;
  logic [CW-1:0] r_rep_cnt;
  logic          r_sel_q;
  logic          w_sel_chg;

  assign w_sel_chg = i_sel ^ r_sel_q;
  assign w_rep_inc = r_rep_active & i_pulse & i_set_en & ~w_sel_chg &
                     (r_rep_cnt == C_REP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rep_active <= 1'b0;
      r_rep_cnt    <= '0;
      r_sel_q      <= 1'b0;
    end else begin
      r_sel_q <= i_sel;
      if (i_set_en && w_inc_req) begin
        // A fresh accepted edge restarts the repeat interval.
        r_rep_active <= 1'b1;
        r_rep_cnt    <= '0;
      end else if (!i_set_en || !i_pulse || w_sel_chg) begin
        r_rep_active <= 1'b0;
        r_rep_cnt    <= '0;
      end else if (r_rep_active) begin
        if (r_rep_cnt == C_REP_LAST)
          r_rep_cnt <= '0;
        else
          r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end
`else
  assign w_rep_inc = 1'b0;
`endif

  assign w_set_inc = i_set_en & (w_inc_req | w_rep_inc);

  always_comb begin
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hour_nxt  = r_hour;
    w_carry_nxt = 1'b0;
    if (i_set_en) begin
      w_sec_nxt = 8'h00;
      if (w_set_inc) begin
        if (i_sel)
          w_hour_nxt = f_bcd_inc(r_hour, C_HOUR_MAX_BCD);
        else
          w_min_nxt = f_bcd_inc(r_min, C_MAX59);
      end
    end else if (i_tick) begin
      w_sec_nxt = f_bcd_inc(r_sec, C_MAX59);
      if (r_sec == C_MAX59) begin
        w_min_nxt = f_bcd_inc(r_min, C_MAX59);
        if (r_min == C_MAX59) begin
          w_hour_nxt = f_bcd_inc(r_hour, C_HOUR_MAX_BCD);
          if (r_hour == C_HOUR_MAX_BCD)
            w_carry_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sec       <= 8'h00;
      r_min       <= 8'h00;
      r_hour      <= 8'h00;
      r_carry_day <= 1'b0;
      r_pulse_q   <= 1'b1;
    end else begin
      r_sec       <= w_sec_nxt;
      r_min       <= w_min_nxt;
      r_hour      <= w_hour_nxt;
      r_carry_day <= w_carry_nxt;
      r_pulse_q   <= i_pulse;
    end
  end

  assign o_sec_bcd   = r_sec;
  assign o_min_bcd   = r_min;
  assign o_hour_bcd  = r_hour;
  assign o_carry_day = r_carry_day;

endmodule

// File: tb/tb_time_set_counter.sv
// Directed bench for time_set_counter. Two instances share all inputs:
// dut (HOUR_MAX = 23) and dut_h11 (HOUR_MAX = 11), both REPEAT_CYCLES = 4.
module tb_time_set_counter;

  logic clk = 1'b0;
  logic i_rst = 1'b1, i_tick = 1'b0, i_set_en = 1'b0, i_sel = 1'b0, i_pulse = 1'b0;
  logic [7:0] sec, min, hour;
  logic       carry;
  logic [7:0] sec11, min11, hour11;
  logic       carry11;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  time_set_counter #(.HOUR_MAX(23), .REPEAT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_tick(i_tick), .i_set_en(i_set_en),
    .i_sel(i_sel), .i_pulse(i_pulse),
    .o_sec_bcd(sec), .o_min_bcd(min), .o_hour_bcd(hour), .o_carry_day(carry)
  );

  time_set_counter #(.HOUR_MAX(11), .REPEAT_CYCLES(4)) dut_h11 (
    .i_clk(clk), .i_rst(i_rst), .i_tick(i_tick), .i_set_en(i_set_en),
    .i_sel(i_sel), .i_pulse(i_pulse),
    .o_sec_bcd(sec11), .o_min_bcd(min11), .o_hour_bcd(hour11), .o_carry_day(carry11)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_n(input int n);
    for (int k = 0; k < n; k++) begin
      i_pulse = 1'b1; step();
      i_pulse = 1'b0; step();
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_tick = 1'b1; step();
      i_tick = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; step(); step();
    i_rst = 1'b0; step();
  endtask

  initial begin
    // Reset with pulse held high in set mode: no increment on release.
    i_pulse = 1'b1; i_set_en = 1'b1; i_sel = 1'b0;
    step(); step();
    chk("rst_sec", sec, 8'h00);
    chk("rst_min", min, 8'h00);
    chk("rst_hour", hour, 8'h00);
    chk("rst_carry", {7'd0, carry}, 8'h00);
    i_rst = 1'b0;
    step(); step(); step();
    chk("rel_hold_min", min, 8'h00);
    i_pulse = 1'b0; step();
    i_pulse = 1'b1; step();
    chk("rel_edge_min", min, 8'h01);
    i_pulse = 1'b0; step();

    // Preset 23:59:58 then roll over.
    do_reset();
    i_set_en = 1'b1; i_sel = 1'b1; edge_n(23);
    i_sel = 1'b0; edge_n(59);
    chk("preset_hour", hour, 8'h23);
    chk("preset_min", min, 8'h59);
    chk("preset_sec", sec, 8'h00);
    chk("preset_hour11", hour11, 8'h11);
    i_set_en = 1'b0; ticks(58);
    chk("run_sec58", sec, 8'h58);
    i_tick = 1'b1; step();
    chk("run_sec59", sec, 8'h59);
    chk("run_nocarry", {7'd0, carry}, 8'h00);
    i_tick = 1'b0; step();
    i_tick = 1'b1; step();
    chk("roll_sec", sec, 8'h00);
    chk("roll_min", min, 8'h00);
    chk("roll_hour", hour, 8'h00);
    chk("roll_carry", {7'd0, carry}, 8'h01);
    chk("roll_hour11", hour11, 8'h00);
    chk("roll_carry11", {7'd0, carry11}, 8'h01);
    i_tick = 1'b0; step();
    chk("carry_one_cycle", {7'd0, carry}, 8'h00);

    // Set mode minutes 58 -> 59 -> 00 -> 01, hours untouched, ticks ignored.
    i_set_en = 1'b1; i_sel = 1'b1; edge_n(7);
    i_sel = 1'b0; edge_n(58);
    chk("set_min58", min, 8'h58);
    i_tick = 1'b1;
    i_pulse = 1'b1; step();
    chk("set_min59", min, 8'h59);
    chk("set_sec0_a", sec, 8'h00);
    chk("set_hour7_a", hour, 8'h07);
    i_pulse = 1'b0; step();
    i_pulse = 1'b1; step();
    chk("set_min00", min, 8'h00);
    chk("set_hour7_b", hour, 8'h07);
    i_pulse = 1'b0; step();
    i_pulse = 1'b1; step();
    chk("set_min01", min, 8'h01);
    i_pulse = 1'b0; i_tick = 1'b0; step();
    chk("set_sec0_b", sec, 8'h00);

    // Hours 22 -> 23 -> 00 (HOUR_MAX 23); instance 11 goes 10 -> 11 -> 00.
    i_sel = 1'b1; edge_n(15);
    chk("hour22", hour, 8'h22);
    chk("hour11_10", hour11, 8'h10);
    edge_n(1);
    chk("hour23", hour, 8'h23);
    chk("hour11_11", hour11, 8'h11);
    edge_n(1);
    chk("hour_wrap", hour, 8'h00);
    chk("hour11_wrap", hour11, 8'h00);
    chk("hour_wrap_min", min, 8'h01);
    do_reset();
    edge_n(11);
    chk("h11_at11", hour11, 8'h11);
    edge_n(1);
    chk("h11_to00", hour11, 8'h00);
    chk("h23_to12", hour, 8'h12);

    // Simultaneous tick and pulse edge at 10:20:30.
    do_reset();
    i_set_en = 1'b1; i_sel = 1'b1; edge_n(10);
    i_sel = 1'b0; edge_n(20);
    i_set_en = 1'b0; ticks(30);
    chk("pre_sec30", sec, 8'h30);
    i_tick = 1'b1; i_pulse = 1'b1; step();
    chk("run_both_sec", sec, 8'h31);
    chk("run_both_min", min, 8'h20);
    chk("run_both_hour", hour, 8'h10);
    i_tick = 1'b0; i_pulse = 1'b0; step();
    i_set_en = 1'b1; i_sel = 1'b0; i_tick = 1'b1; i_pulse = 1'b1; step();
    chk("set_both_min", min, 8'h21);
    chk("set_both_sec", sec, 8'h00);
    i_tick = 1'b0; i_pulse = 1'b0; step();
    i_sel = 1'b1; i_pulse = 1'b1; step();
    chk("sel_chg_hour", hour, 8'h11);
    chk("sel_chg_min", min, 8'h21);
    i_pulse = 1'b0; step();

    // Pulse held high 13 cycles from minutes 05.
    do_reset();
    i_set_en = 1'b1; i_sel = 1'b0; edge_n(5);
    chk("hold_pre_min", min, 8'h05);
    i_pulse = 1'b1;
    repeat (13) step();
`ifdef AUTO_REPEAT_EN
    chk("hold_min", min, 8'h08);
`else
    chk("hold_min", min, 8'h06);
`endif
    i_pulse = 1'b0;
    repeat (10) step();
`ifdef AUTO_REPEAT_EN
    chk("release_min", min, 8'h08);
`else
    chk("release_min", min, 8'h06);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
